// File: rtl/a2_slot_bus_host_if.sv
// Apple II slot bus and command/response port of the slot bus host.
// The master modport is the host side; the slave modport is the card/command side.
interface a2_slot_bus_host_if;
  logic        PHI0;
  logic        PHI1;
  logic [15:0] A;
  logic        nWE;
  logic        nDEVSEL;
  logic        nIOSEL;
  logic        nIOSTRB;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic        cmd_rnw;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cycle_long;

  modport master (
    output PHI0, PHI1, A, nWE, nDEVSEL, nIOSEL, nIOSTRB,
    input  cmd_valid, cmd_addr, cmd_rnw, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, cycle_long
  );

  modport slave (
    input  PHI0, PHI1, A, nWE, nDEVSEL, nIOSEL, nIOSTRB,
    output cmd_valid, cmd_addr, cmd_rnw, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, cycle_long
  );
endinterface

// File: rtl/a2_slot_bus_host.sv
// Apple II bus initiator: derives PHI0/PHI1 from C7M and turns each accepted
// command into exactly one 6502 bus cycle, with idle cycles in between.
module a2_slot_bus_host #(
  parameter int unsigned SLOT        = 1,
  parameter int unsigned LONG_PERIOD = 65,
  parameter logic [15:0] IDLE_ADDR   = 16'h0000
) (
  input  logic               C7M,
  input  logic               nRES,
  a2_slot_bus_host_if.master bus,
  inout  wire  [7:0]         D
);

  typedef enum logic [2:0] {StS1, StS2, StS3, StS4, StS5, StS6, StS7, StS8} state_e;

  localparam int unsigned     CntW       = (LONG_PERIOD > 1) ? $clog2(LONG_PERIOD) : 1;
  localparam bit              LongEn     = (LONG_PERIOD != 0);
  localparam logic [CntW-1:0] LongLast   = LongEn ? CntW'(LONG_PERIOD - 1) : '0;
  localparam logic [11:0]     DevselPage = 12'hC08 + 12'(SLOT);
  localparam logic [7:0]      IoselPage  = 8'hC0 + 8'(SLOT);

  state_e          state_q, state_d;
  logic            phi0_q, phi0_d;
  logic            phi1_q, phi1_d;
  logic [CntW-1:0] long_cnt_q, long_cnt_d;

  // Holding register (queued command) and the command owning the current bus cycle.
  logic            hold_valid_q, hold_valid_d;
  logic [15:0]     hold_addr_q, hold_addr_d;
  logic            hold_rnw_q, hold_rnw_d;
  logic [7:0]      hold_wdata_q, hold_wdata_d;
  logic            cur_valid_q, cur_valid_d;
  logic [15:0]     cur_addr_q, cur_addr_d;
  logic            cur_rnw_q, cur_rnw_d;
  logic [7:0]      cur_wdata_q, cur_wdata_d;

  logic [15:0]     a_q, a_d;
  logic            nwe_q, nwe_d;
  logic            ndevsel_q, ndevsel_d;
  logic            niosel_q, niosel_d;
  logic            niostrb_q, niostrb_d;
  logic            d_oe_q, d_oe_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic            long_now;
  logic            last_state;
  logic            accept;
  logic            dev_hit, io_hit, strb_hit;

  assign long_now   = LongEn && (long_cnt_q == LongLast);
  assign last_state = (state_q == StS8) || ((state_q == StS7) && !long_now);
  assign accept     = bus.cmd_valid && !hold_valid_q;

  assign dev_hit  = (a_q[15:4] == DevselPage);
  assign io_hit   = (a_q[15:8] == IoselPage);
  assign strb_hit = (a_q[15:11] == 5'b11001);

  always_comb begin
    state_d      = state_q;
    long_cnt_d   = long_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_rnw_d   = hold_rnw_q;
    hold_wdata_d = hold_wdata_q;
    cur_valid_d  = cur_valid_q;
    cur_addr_d   = cur_addr_q;
    cur_rnw_d    = cur_rnw_q;
    cur_wdata_d  = cur_wdata_q;
    a_d          = a_q;
    nwe_d        = nwe_q;
    ndevsel_d    = ndevsel_q;
    niosel_d     = niosel_q;
    niostrb_d    = niostrb_q;
    d_oe_d       = d_oe_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = bus.cmd_addr;
      hold_rnw_d   = bus.cmd_rnw;
      hold_wdata_d = bus.cmd_wdata;
    end

    unique case (state_q)
      StS1: begin
        state_d = StS2;
        a_d     = cur_valid_q ? cur_addr_q : IDLE_ADDR;
        nwe_d   = cur_valid_q ? cur_rnw_q : 1'b1;
      end
      StS2: state_d = StS3;
      StS3: begin
        state_d = StS4;
        // Idle cycles never select, even if IDLE_ADDR decodes to a slot range.
        ndevsel_d = !(cur_valid_q && dev_hit);
        niosel_d  = !(cur_valid_q && io_hit);
        niostrb_d = !(cur_valid_q && strb_hit);
      end
      StS4: begin
        state_d = StS5;
        d_oe_d  = cur_valid_q && !cur_rnw_q;
      end
      StS5: state_d = StS6;
      StS6: state_d = StS7;
      StS7: state_d = StS8;
      StS8: state_d = StS1;
      default: state_d = StS1;
    endcase

    if (last_state) begin
      state_d    = StS1;
      ndevsel_d  = 1'b1;
      niosel_d   = 1'b1;
      niostrb_d  = 1'b1;
      d_oe_d     = 1'b0;
      long_cnt_d = (long_cnt_q == LongLast) ? '0 : long_cnt_q + CntW'(1);
      if (cur_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cur_rnw_q ? D : 8'h00;
      end
      // The queued command becomes the next bus cycle and frees the holding register.
      cur_valid_d = hold_valid_q;
      if (hold_valid_q) begin
        cur_addr_d   = hold_addr_q;
        cur_rnw_d    = hold_rnw_q;
        cur_wdata_d  = hold_wdata_q;
        hold_valid_d = 1'b0;
      end
    end

    phi1_d = (state_d == StS1) || (state_d == StS2) || (state_d == StS3);
    phi0_d = !phi1_d;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_q      <= StS1;
      phi0_q       <= 1'b0;
      phi1_q       <= 1'b1;
      long_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 16'h0000;
      hold_rnw_q   <= 1'b1;
      hold_wdata_q <= 8'h00;
      cur_valid_q  <= 1'b0;
      cur_addr_q   <= 16'h0000;
      cur_rnw_q    <= 1'b1;
      cur_wdata_q  <= 8'h00;
      a_q          <= IDLE_ADDR;
      nwe_q        <= 1'b1;
      ndevsel_q    <= 1'b1;
      niosel_q     <= 1'b1;
      niostrb_q    <= 1'b1;
      d_oe_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      phi0_q       <= phi0_d;
      phi1_q       <= phi1_d;
      long_cnt_q   <= long_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_rnw_q   <= hold_rnw_d;
      hold_wdata_q <= hold_wdata_d;
      cur_valid_q  <= cur_valid_d;
      cur_addr_q   <= cur_addr_d;
      cur_rnw_q    <= cur_rnw_d;
      cur_wdata_q  <= cur_wdata_d;
      a_q          <= a_d;
      nwe_q        <= nwe_d;
      ndevsel_q    <= ndevsel_d;
      niosel_q     <= niosel_d;
      niostrb_q    <= niostrb_d;
      d_oe_q       <= d_oe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.PHI0       = phi0_q;
  assign bus.PHI1       = phi1_q;
  assign bus.A          = a_q;
  assign bus.nWE        = nwe_q;
  assign bus.nDEVSEL    = ndevsel_q;
  assign bus.nIOSEL     = niosel_q;
  assign bus.nIOSTRB    = niostrb_q;
  assign bus.cmd_ready  = !hold_valid_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.cycle_long = long_now;

  assign D = d_oe_q ? cur_wdata_q : {8{1'bz}};

endmodule

// File: tb/tb_a2_slot_bus_host.sv
// Directed bench for a2_slot_bus_host (SLOT=6): vector table of single bus cycles
// plus hand sequences for back-to-back, long-cycle and mid-cycle reset cases.
module tb_a2_slot_bus_host;
  logic       c7m  = 1'b0;
  logic       nres = 1'b0;
  wire  [7:0] d;
  logic       resp_oe   = 1'b1;
  logic [7:0] resp_data = 8'h5A;

  assign d = resp_oe ? resp_data : 8'hzz;

  a2_slot_bus_host_if bus ();

  a2_slot_bus_host #(
    .SLOT       (6),
    .LONG_PERIOD(65),
    .IDLE_ADDR  (16'h0000)
  ) dut (
    .C7M (c7m),
    .nRES(nres),
    .bus (bus),
    .D   (d)
  );

  always #70 c7m = ~c7m;

  // Reference sequencer: bus state 1..8 and long-cycle counter.
  int   m_s   = 1;
  int   m_cnt = 0;
  logic m_long, m_last;
  always_comb begin
    m_long = (m_cnt == 64);
    m_last = (m_s == 8) || ((m_s == 7) && !m_long);
  end
  always @(posedge c7m or negedge nres) begin
    if (!nres) begin
      m_s   <= 1;
      m_cnt <= 0;
    end else if (m_last) begin
      m_s   <= 1;
      m_cnt <= (m_cnt == 64) ? 0 : m_cnt + 1;
    end else begin
      m_s <= m_s + 1;
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (S%0d cnt%0d): got %h, want %h", name, m_s, m_cnt, act, exp);
    end
  endtask

  task automatic chk_phase();
    chk("PHI1", bus.PHI1, m_s <= 3);
    chk("PHI0", bus.PHI0, m_s >= 4);
    chk("cycle_long", bus.cycle_long, m_long);
  endtask

  function automatic logic [2:0] sels();
    return {bus.nDEVSEL, bus.nIOSEL, bus.nIOSTRB};
  endfunction

  task automatic wait_s(input int s);
    int k = 0;
    do begin
      @(negedge c7m);
      k++;
    end while (m_s != s && k < 40);
    if (m_s != s) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_s: timeout waiting for S%0d", s);
    end
  endtask

  task automatic wait_last();
    int k = 0;
    do begin
      @(negedge c7m);
      k++;
    end while (!m_last && k < 40);
  endtask

  // Present a command in S2 of an idle cycle; it is accepted on the next edge.
  task automatic send(input logic [15:0] addr, input logic rnw, input logic [7:0] wd,
                      input bit keep);
    wait_s(2);
    bus.cmd_addr  = addr;
    bus.cmd_rnw   = rnw;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    chk("ready before accept", bus.cmd_ready, 1'b1);
    @(negedge c7m);
    chk("ready after accept", bus.cmd_ready, 1'b0);
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  // Called at the S1 negedge of a commanded cycle; returns at S1 of the next cycle.
  task automatic run_cycle(input logic [15:0] addr, input logic rnw, input logic [7:0] wd,
                           input logic [7:0] rd, input logic [2:0] sel_n,
                           input logic [7:0] exp_rdata, input bit queued);
    int k = 0;
    chk_phase();
    do begin
      @(negedge c7m);
      k++;
      chk_phase();
      chk("A", bus.A, addr);
      chk("nWE", bus.nWE, rnw);
      chk("selects", sels(), (m_s >= 4) ? sel_n : 3'b111);
      if (m_s <= 4) chk("D undriven", d, 8'h5A);
      else if (!rnw) chk("D wdata", d, wd);
      chk("rsp_valid in cycle", bus.rsp_valid, 1'b0);
      if (queued && m_s == 2) begin
        chk("ready queued", bus.cmd_ready, 1'b0);
        bus.cmd_valid = 1'b0;
      end
      if (m_s == 4) begin
        if (rnw) resp_data = rd;
        else resp_oe = 1'b0;
      end
    end while (!m_last && k < 12);
    @(negedge c7m);
    chk_phase();
    chk("rsp_valid pulse", bus.rsp_valid, 1'b1);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("selects released", sels(), 3'b111);
    resp_oe   = 1'b1;
    resp_data = 8'h5A;
    #1;
    chk("D released", d, 8'h5A);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic [7:0]  bus_rd;
    logic [2:0]  sel_n;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {addr, rnw, wdata, card data, {nDEVSEL,nIOSEL,nIOSTRB}, rsp_rdata}
    vecs[0] = '{16'hC0E0, 1'b0, 8'hA5, 8'h00, 3'b011, 8'h00};
    vecs[1] = '{16'hC600, 1'b1, 8'h00, 8'h3C, 3'b101, 8'h3C};
    vecs[2] = '{16'hC0EF, 1'b1, 8'h00, 8'h81, 3'b011, 8'h81};
    vecs[3] = '{16'hCFFF, 1'b0, 8'h7E, 8'h00, 3'b110, 8'h00};
    vecs[4] = '{16'hC0D0, 1'b1, 8'h00, 8'h42, 3'b111, 8'h42};
    vecs[5] = '{16'hC700, 1'b1, 8'h00, 8'h99, 3'b111, 8'h99};
    vecs[6] = '{16'hC800, 1'b0, 8'h11, 8'h00, 3'b110, 8'h00};
    vecs[7] = '{16'h1234, 1'b1, 8'h00, 8'hAA, 3'b111, 8'hAA};
    vecs[8] = '{16'hC6FF, 1'b0, 8'h55, 8'h00, 3'b101, 8'h00};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_rnw   = 1'b1;
    bus.cmd_wdata = 8'h00;

    // Reset state
    @(negedge c7m);
    chk("rst PHI1", bus.PHI1, 1'b1);
    chk("rst PHI0", bus.PHI0, 1'b0);
    chk("rst A", bus.A, 16'h0000);
    chk("rst nWE", bus.nWE, 1'b1);
    chk("rst selects", sels(), 3'b111);
    chk("rst cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst rsp_rdata", bus.rsp_rdata, 8'h00);
    chk("rst D", d, 8'h5A);
    nres = 1'b1;

    // Free run through one long cycle (cycle 64)
    repeat (70 * 7 + 1) begin
      @(negedge c7m);
      chk_phase();
      chk("free selects", sels(), 3'b111);
      chk("free D", d, 8'h5A);
      chk("free rsp_valid", bus.rsp_valid, 1'b0);
    end

    // Single commanded cycles
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, 1'b0);
      wait_s(1);
      chk("ready at issue", bus.cmd_ready, 1'b1);
      chk("A idle in S1", bus.A, 16'h0000);
      chk("nWE idle in S1", bus.nWE, 1'b1);
      run_cycle(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, vecs[i].bus_rd, vecs[i].sel_n,
                vecs[i].exp_rdata, 1'b0);
      @(negedge c7m);
      chk("rsp_valid one clock", bus.rsp_valid, 1'b0);
    end

    // Back-to-back: CFFF then C800 queued, with junk fields while not ready
    send(16'hCFFF, 1'b1, 8'h00, 1'b1);
    bus.cmd_addr  = 16'hC0E5;
    bus.cmd_rnw   = 1'b0;
    bus.cmd_wdata = 8'hEE;
    wait_last();
    chk("ready while held", bus.cmd_ready, 1'b0);
    bus.cmd_addr  = 16'hC800;
    bus.cmd_rnw   = 1'b1;
    bus.cmd_wdata = 8'h00;
    wait_s(1);
    chk("b2b ready at issue", bus.cmd_ready, 1'b1);
    chk("b2b A idle in S1", bus.A, 16'h0000);
    run_cycle(16'hCFFF, 1'b1, 8'h00, 8'h3C, 3'b110, 8'h3C, 1'b1);
    chk("b2b ready at 2nd start", bus.cmd_ready, 1'b1);
    run_cycle(16'hC800, 1'b1, 8'h00, 8'hC3, 3'b110, 8'hC3, 1'b0);
    @(negedge c7m);
    chk("b2b rsp_valid one clock", bus.rsp_valid, 1'b0);

    // Command in the long cycle (count 64), then a normal-length cycle
    begin
      int k = 0;
      while (!(m_cnt == 63 && m_s == 1) && k < 1000) begin
        @(negedge c7m);
        k++;
      end
    end
    send(16'hC0E3, 1'b1, 8'h00, 1'b0);
    wait_s(1);
    run_cycle(16'hC0E3, 1'b1, 8'h00, 8'h66, 3'b011, 8'h66, 1'b0);
    repeat (8) begin
      @(negedge c7m);
      chk_phase();
      chk("post-long selects", sels(), 3'b111);
    end

    // Reset during S5 of a write with a read queued behind it
    send(16'hC0E0, 1'b0, 8'hA5, 1'b1);
    bus.cmd_addr  = 16'hC600;
    bus.cmd_rnw   = 1'b1;
    bus.cmd_wdata = 8'h00;
    wait_s(2);
    chk("rst-test queued", bus.cmd_ready, 1'b0);
    bus.cmd_valid = 1'b0;
    resp_oe = 1'b0;
    wait_s(5);
    chk("rst-test D before", d, 8'hA5);
    chk("rst-test nDEVSEL before", bus.nDEVSEL, 1'b0);
    nres      = 1'b0;
    resp_oe   = 1'b1;
    resp_data = 8'h5A;
    #1;
    chk("mid rst D", d, 8'h5A);
    chk("mid rst selects", sels(), 3'b111);
    chk("mid rst PHI1", bus.PHI1, 1'b1);
    chk("mid rst PHI0", bus.PHI0, 1'b0);
    chk("mid rst A", bus.A, 16'h0000);
    chk("mid rst nWE", bus.nWE, 1'b1);
    chk("mid rst cmd_ready", bus.cmd_ready, 1'b1);
    chk("mid rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid rst rsp_rdata", bus.rsp_rdata, 8'h00);
    repeat (2) @(negedge c7m);
    nres = 1'b1;
    repeat (15) begin
      @(negedge c7m);
      chk_phase();
      chk("post rst A", bus.A, 16'h0000);
      chk("post rst nWE", bus.nWE, 1'b1);
      chk("post rst selects", sels(), 3'b111);
      chk("post rst D", d, 8'h5A);
      chk("post rst rsp_valid", bus.rsp_valid, 1'b0);
      chk("post rst cmd_ready", bus.cmd_ready, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
